// File: rtl/fmadd_mul_iter_front.sv
// FMADD multiply front end: operand unpack/classify, shift-add
// mantissa product and leading-zero count behind valid/ready.
module fmadd_mul_iter_front #(
  parameter int std  = 31,
  parameter int man  = 22,
  parameter int exp  = 7,
  parameter int bias = 127,
  parameter int lzd  = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [std:0]       in_a,
  input  logic [std:0]       in_b,
  input  logic [2:0]         in_rm,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_sign,
  output logic [exp+1:0]     out_exp_DB,
  output logic [2*man+3:0]   out_multiplied_man,
  output logic [lzd:0]       out_lzd,
  output logic [2:0]         out_rm,
  output logic               out_A_neg,
  output logic               out_A_pos,
  output logic               out_A_sub,
  output logic               out_B_neg,
  output logic               out_B_pos,
  output logic               out_B_sub
);

  localparam int EW = exp + 1;
  localparam int MW = man + 2;
  localparam int PW = 2 * man + 4;
  localparam int CW = $clog2(MW + 1);
  localparam int LW = lzd + 1;
  localparam int ZW = $clog2(PW + 1);
  localparam logic [LW-1:0] LZ_SAT = LW'((1 << LW) - 2);
  localparam logic [EW-1:0] BIAS_E = EW'(bias);

  typedef enum logic [1:0] {IDLE, MUL, LZC, DONE} state_t;

  state_t state_q, state_d;

  logic [EW-1:0] ea, eb;
  logic [MW-1:0] ma_x, mb_x;
  logic [5:0]    cls;

  logic [MW-1:0] mcand_q, mplr_q;
  logic [PW-1:0] acc_q;
  logic [CW-1:0] cnt_q;
  logic          sign_q;
  logic [EW:0]   expdb_q;
  logic [5:0]    cls_q;
  logic [2:0]    rm_q;

  logic [MW:0]   mul_sum;
  logic [PW-1:0] acc_step;
  logic [ZW-1:0] lz_cnt;
  logic          lz_hit;
  logic [LW-1:0] lz_sat;

  assign ea   = in_a[std-1:man+1];
  assign eb   = in_b[std-1:man+1];
  assign ma_x = {|ea, in_a[man:0]};
  assign mb_x = {|eb, in_b[man:0]};

  assign cls = {(ea != '0) && (ea < BIAS_E), ea >= BIAS_E, ea == '0,
                (eb != '0) && (eb < BIAS_E), eb >= BIAS_E, eb == '0};

  assign in_ready = (state_q == IDLE);

  // Carry out of the upper-half add shifts back in at the top.
  assign mul_sum  = {1'b0, acc_q[PW-1:MW]}
                  + (mplr_q[0] ? {1'b0, mcand_q} : '0);
  assign acc_step = {mul_sum, acc_q[MW-1:1]};

  always_comb begin
    lz_cnt = '0;
    lz_hit = 1'b0;
    for (int i = PW - 1; i >= 0; i--) begin
      if (!lz_hit) begin
        if (acc_q[i]) lz_hit = 1'b1;
        else          lz_cnt = lz_cnt + 1'b1;
      end
    end
    lz_sat = (lz_cnt > ZW'(LZ_SAT)) ? LZ_SAT : lz_cnt[LW-1:0];
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (in_valid)
              state_d = (ma_x == '0 || mb_x == '0) ? LZC : MUL;
      MUL:  if (cnt_q == CW'(1)) state_d = LZC;
      LZC:  state_d = DONE;
      DONE: if (out_valid && out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q            <= IDLE;
      mcand_q            <= '0;
      mplr_q             <= '0;
      acc_q              <= '0;
      cnt_q              <= '0;
      sign_q             <= 1'b0;
      expdb_q            <= '0;
      cls_q              <= '0;
      rm_q               <= '0;
      out_valid          <= 1'b0;
      out_sign           <= 1'b0;
      out_exp_DB         <= '0;
      out_multiplied_man <= '0;
      out_lzd            <= '0;
      out_rm             <= '0;
      {out_A_neg, out_A_pos, out_A_sub,
       out_B_neg, out_B_pos, out_B_sub} <= '0;
    end else begin
      state_q   <= state_d;
      out_valid <= (state_q == DONE) && !(out_valid && out_ready);
      unique case (state_q)
        IDLE: if (in_valid) begin
          mcand_q <= ma_x;
          mplr_q  <= mb_x;
          acc_q   <= '0;
          cnt_q   <= CW'(MW);
          sign_q  <= in_a[std] ^ in_b[std];
          expdb_q <= {1'b0, ea} + {1'b0, eb};
          cls_q   <= cls;
          rm_q    <= in_rm;
        end
        MUL: begin
          acc_q  <= acc_step;
          mplr_q <= mplr_q >> 1;
          cnt_q  <= cnt_q - 1'b1;
        end
        LZC: begin
          out_sign           <= sign_q;
          out_exp_DB         <= expdb_q;
          out_multiplied_man <= acc_q;
          out_lzd            <= lz_sat;
          out_rm             <= rm_q;
          {out_A_neg, out_A_pos, out_A_sub,
           out_B_neg, out_B_pos, out_B_sub} <= cls_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fmadd_mul_iter_front.sv
// Bench for fmadd_mul_iter_front: directed table, random ops
// against an arithmetic model, hold, back-to-back and reset.
module tb_fmadd_mul_iter_front;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a, in_b;
  logic [2:0]  in_rm;
  logic        out_valid;
  logic        out_ready;
  logic        out_sign;
  logic [8:0]  out_exp_DB;
  logic [47:0] out_multiplied_man;
  logic [4:0]  out_lzd;
  logic [2:0]  out_rm;
  logic        out_A_neg, out_A_pos, out_A_sub;
  logic        out_B_neg, out_B_pos, out_B_sub;

  int nvec = 0;
  int nerr = 0;

  typedef struct {
    logic        sign;
    logic [8:0]  expdb;
    logic [47:0] man;
    logic [4:0]  lzd;
    logic [5:0]  flags;
    logic [2:0]  rm;
    int          lat;
  } res_t;

  fmadd_mul_iter_front dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_rm(in_rm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sign(out_sign), .out_exp_DB(out_exp_DB),
    .out_multiplied_man(out_multiplied_man),
    .out_lzd(out_lzd), .out_rm(out_rm),
    .out_A_neg(out_A_neg), .out_A_pos(out_A_pos),
    .out_A_sub(out_A_sub), .out_B_neg(out_B_neg),
    .out_B_pos(out_B_pos), .out_B_sub(out_B_sub)
  );

  always #5 clk = ~clk;

  function automatic res_t model(input logic [31:0] a,
                                 input logic [31:0] b,
                                 input logic [2:0] rm);
    res_t m;
    logic [7:0] ea, eb;
    logic [63:0] ma, mb, p;
    int lz;
    ea = a[30:23];
    eb = b[30:23];
    ma = {40'd0, ea != 8'd0, a[22:0]};
    mb = {40'd0, eb != 8'd0, b[22:0]};
    p = ma * mb;
    lz = 48;
    for (int i = 0; i < 48; i++) if (p[i]) lz = 47 - i;
    if (lz > 30) lz = 30;
    m.sign  = a[31] ^ b[31];
    m.expdb = {1'b0, ea} + {1'b0, eb};
    m.man   = p[47:0];
    m.lzd   = 5'(lz);
    m.flags = {ea != 0 && ea < 127, ea >= 127, ea == 0,
               eb != 0 && eb < 127, eb >= 127, eb == 0};
    m.rm    = rm;
    m.lat   = (ma == 0 || mb == 0) ? 2 : 26;
    return m;
  endfunction

  // Drives one operation; lat stays -1 if out_valid never rises.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                       input logic [2:0] rm, input logic rdy,
                       output res_t o);
    o.lat = -1;
    in_a = a; in_b = b; in_rm = rm;
    in_valid = 1'b1;
    out_ready = rdy;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk); #1;
      if (out_valid) begin
        o.lat = k;
        break;
      end
    end
    o.sign  = out_sign;
    o.expdb = out_exp_DB;
    o.man   = out_multiplied_man;
    o.lzd   = out_lzd;
    o.rm    = out_rm;
    o.flags = {out_A_neg, out_A_pos, out_A_sub,
               out_B_neg, out_B_pos, out_B_sub};
    if (rdy && o.lat > 0) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0; in_a = '0; in_b = '0; in_rm = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    nvec++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      nerr++;
      $display("FAIL reset_hs: got rdy=%b vld=%b want 1 0",
               in_ready, out_valid);
    end
    nvec++;
    if ({out_multiplied_man, out_exp_DB, out_lzd, out_sign,
         out_rm} !== '0) begin
      nerr++;
      $display("FAIL reset_out: got man=%h exp=%h lzd=%0d want 0",
               out_multiplied_man, out_exp_DB, out_lzd);
    end
  endtask

  task automatic test_directed();
    logic [31:0] ta[5] = '{32'h3F800000, 32'h3FC00000, 32'hC0000000,
                           32'h00000001, 32'h00000000};
    logic [31:0] tb[5] = '{32'h3F800000, 32'h3FC00000, 32'h3F000000,
                           32'h3F800000, 32'h40490FDB};
    logic        ws[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [8:0]  we[5] = '{9'h0FE, 9'h0FE, 9'h0FE, 9'h07F, 9'h080};
    logic [47:0] wm[5] = '{48'h400000000000, 48'h900000000000,
                           48'h400000000000, 48'h000000800000, 48'h0};
    logic [4:0]  wl[5] = '{5'd1, 5'd0, 5'd1, 5'd24, 5'd30};
    logic [5:0]  wf[5] = '{6'b010010, 6'b010010, 6'b010100,
                           6'b001010, 6'b001010};
    int          wt[5] = '{26, 26, 26, 26, 2};
    res_t o;
    for (int i = 0; i < 5; i++) begin
      do_op(ta[i], tb[i], 3'(i), 1'b1, o);
      nvec++;
      if (o.lat != wt[i]) begin
        nerr++;
        $display("FAIL dir%0d lat: got %0d want %0d", i, o.lat, wt[i]);
      end
      nvec++;
      if (o.sign !== ws[i] || o.expdb !== we[i]) begin
        nerr++;
        $display("FAIL dir%0d sign/exp: got %b %h want %b %h",
                 i, o.sign, o.expdb, ws[i], we[i]);
      end
      nvec++;
      if (o.man !== wm[i] || o.lzd !== wl[i]) begin
        nerr++;
        $display("FAIL dir%0d man/lzd: got %h %0d want %h %0d",
                 i, o.man, o.lzd, wm[i], wl[i]);
      end
      nvec++;
      if (o.flags !== wf[i] || o.rm !== 3'(i)) begin
        nerr++;
        $display("FAIL dir%0d flags/rm: got %b %0d want %b %0d",
                 i, o.flags, o.rm, wf[i], i);
      end
    end
  endtask

  task automatic test_random();
    res_t o, m;
    logic [31:0] a, b;
    logic [2:0] rm;
    for (int i = 0; i < 40; i++) begin
      a = $urandom; b = $urandom; rm = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 7) == 0) a[30:23] = 8'd0;
      if ($urandom_range(0, 7) == 0) b[30:23] = 8'd0;
      if ($urandom_range(0, 15) == 0) a[22:0] = 23'd0;
      if ($urandom_range(0, 3) == 0) b[30:23] = 8'($urandom_range(120, 134));
      m = model(a, b, rm);
      do_op(a, b, rm, 1'b1, o);
      nvec++;
      if (o.lat != m.lat) begin
        nerr++;
        $display("FAIL rnd%0d lat: got %0d want %0d", i, o.lat, m.lat);
      end
      nvec++;
      if (o.sign !== m.sign || o.expdb !== m.expdb) begin
        nerr++;
        $display("FAIL rnd%0d sign/exp: got %b %h want %b %h",
                 i, o.sign, o.expdb, m.sign, m.expdb);
      end
      nvec++;
      if (o.man !== m.man || o.lzd !== m.lzd) begin
        nerr++;
        $display("FAIL rnd%0d man/lzd a=%h b=%h: got %h %0d want %h %0d",
                 i, a, b, o.man, o.lzd, m.man, m.lzd);
      end
      nvec++;
      if (o.flags !== m.flags || o.rm !== m.rm) begin
        nerr++;
        $display("FAIL rnd%0d flags/rm: got %b %0d want %b %0d",
                 i, o.flags, o.rm, m.flags, m.rm);
      end
    end
  endtask

  task automatic test_hold();
    res_t o, m;
    m = model(32'h3FC00000, 32'hBF400000, 3'd5);
    do_op(32'h3FC00000, 32'hBF400000, 3'd5, 1'b0, o);
    nvec++;
    if (o.lat != 26) begin
      nerr++;
      $display("FAIL hold lat: got %0d want 26", o.lat);
    end
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      nvec++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 ||
          out_multiplied_man !== m.man || out_lzd !== m.lzd ||
          out_exp_DB !== m.expdb || out_sign !== m.sign) begin
        nerr++;
        $display("FAIL hold%0d: got vld=%b rdy=%b man=%h want 1 0 %h",
                 c, out_valid, in_ready, out_multiplied_man, m.man);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    nvec++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      nerr++;
      $display("FAIL hold_release: got vld=%b rdy=%b want 0 1",
               out_valid, in_ready);
    end
  endtask

  task automatic test_back_to_back();
    res_t o, m;
    logic [31:0] a, b;
    for (int i = 0; i < 6; i++) begin
      a = $urandom; b = $urandom;
      if (i == 2) b = 32'h80000000;
      m = model(a, b, 3'd1);
      do_op(a, b, 3'd1, 1'b1, o);
      nvec++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
        nerr++;
        $display("FAIL b2b%0d hs: got rdy=%b vld=%b want 1 0",
                 i, in_ready, out_valid);
      end
      nvec++;
      if (o.lat != m.lat || o.man !== m.man || o.lzd !== m.lzd) begin
        nerr++;
        $display("FAIL b2b%0d res: got %0d %h %0d want %0d %h %0d",
                 i, o.lat, o.man, o.lzd, m.lat, m.man, m.lzd);
      end
    end
  endtask

  task automatic test_reset_mid();
    res_t o, m;
    in_a = 32'h3FC00000; in_b = 32'h40400000; in_rm = 3'd2;
    in_valid = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    nvec++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      nerr++;
      $display("FAIL rstmid_hs: got vld=%b rdy=%b want 0 1",
               out_valid, in_ready);
    end
    nvec++;
    if ({out_multiplied_man, out_exp_DB, out_lzd, out_A_pos,
         out_B_pos, out_B_neg, out_B_sub} !== '0) begin
      nerr++;
      $display("FAIL rstmid_out: got man=%h exp=%h lzd=%0d want 0",
               out_multiplied_man, out_exp_DB, out_lzd);
    end
    for (int c = 0; c < 30; c++) begin
      @(posedge clk); #1;
      if (out_valid) begin
        nvec++;
        nerr++;
        $display("FAIL rstmid_ghost: got vld=1 at %0d want 0", c);
        break;
      end
    end
    m = model(32'h40400000, 32'h3F800001, 3'd4);
    do_op(32'h40400000, 32'h3F800001, 3'd4, 1'b1, o);
    nvec++;
    if (o.lat != m.lat || o.man !== m.man || o.expdb !== m.expdb) begin
      nerr++;
      $display("FAIL rstmid_after: got %0d %h %h want %0d %h %h",
               o.lat, o.man, o.expdb, m.lat, m.man, m.expdb);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_hold();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
